// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command sequencer for the 4-bit ALU core
// Drives ALU operand/opcode pins, waits out ALU latency, queues tagged results.
module alu_cmd_sequencer #(
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [7:0] alu_operands,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_op,
  output logic [3:0] rsp_tag,
  output logic       rsp_dz,
  output logic       busy
);

  localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(ALU_LAT + 2);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic [3:0]      tag;
  logic [3:0]      cur_tag;
  logic            cur_dz;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     mem [RSP_DEPTH];
  logic [15:0]     head;
  logic [15:0]     push_entry;
  logic            accept;
  logic            push;
  logic            pop;
  logic            cmd_dz;

  assign cmd_ready = (state == S_IDLE) && (count < CW'(RSP_DEPTH));
  assign busy      = (state == S_WAIT);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == S_WAIT) && (wait_cnt == '0);
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign cmd_dz    = ((cmd_op == 3'b100) && (cmd_b == 4'd0)) ||
                     ((cmd_op == 3'b101) && (cmd_a == 4'd0));

  // Entry layout: {dz, tag[3:0], op[2:0], data[7:0]}
  assign push_entry = {cur_dz, cur_tag, alu_op, (cur_dz ? 8'hFF : alu_result)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      tag          <= 4'd0;
      cur_tag      <= 4'd0;
      cur_dz       <= 1'b0;
      alu_operands <= 8'h00;
      alu_op       <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_operands <= {cmd_a, cmd_b};
            alu_op       <= cmd_op;
            cur_tag      <= tag;
            cur_dz       <= cmd_dz;
            tag          <= tag + 4'd1;
            wait_cnt     <= WW'(ALU_LAT);
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; outputs are gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head     = mem[rd_ptr];
  assign rsp_data = rsp_valid ? head[7:0]   : 8'h00;
  assign rsp_op   = rsp_valid ? head[10:8]  : 3'b000;
  assign rsp_tag  = rsp_valid ? head[14:11] : 4'd0;
  assign rsp_dz   = rsp_valid ? head[15]    : 1'b0;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
// Directed scenarios plus randomized traffic against a response scoreboard.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic [7:0] alu_operands;
  logic [2:0] alu_op;
  logic [7:0] alu_result = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [2:0] rsp_op;
  logic [3:0] rsp_tag;
  logic       rsp_dz;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] op;
    logic [3:0] tag;
    logic       dz;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_acc = 0;
  int   n_pop = 0;
  logic [3:0] last_pop_tag = 4'd0;

  alu_cmd_sequencer #(.ALU_LAT(1), .RSP_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_operands (alu_operands),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_op       (rsp_op),
    .rsp_tag      (rsp_tag),
    .rsp_dz       (rsp_dz),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ALU core model: registers once; divide by zero yields 0 so forcing is visible.
  always @(posedge clk) begin
    logic [7:0] x, y;
    x = {4'd0, alu_operands[7:4]};
    y = {4'd0, alu_operands[3:0]};
    case (alu_op)
      3'd0: alu_result <= x + y;
      3'd1: alu_result <= x - y;
      3'd2: alu_result <= y - x;
      3'd3: alu_result <= x * y;
      3'd4: alu_result <= (y == 0) ? 8'h00 : x / y;
      3'd5: alu_result <= (x == 0) ? 8'h00 : y / x;
      3'd6: alu_result <= x & y;
      default: alu_result <= x | y;
    endcase
  end

  function automatic rsp_t ref_rsp(input int op, input int a, input int b, input int tag);
    rsp_t r;
    int v;
    r.dz = (op == 4 && b == 0) || (op == 5 && a == 0);
    case (op)
      0: v = a + b;
      1: v = a - b;
      2: v = b - a;
      3: v = a * b;
      4: v = (b == 0) ? 0 : a / b;
      5: v = (a == 0) ? 0 : b / a;
      6: v = a & b;
      default: v = a | b;
    endcase
    r.data = r.dz ? 8'hFF : 8'(v);
    r.op   = 3'(op);
    r.tag  = 4'(tag % 16);
    return r;
  endfunction

  // Scoreboard: accepted commands queue expected responses in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      n_acc = 0;
      n_pop = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 1, 0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("sb_data", rsp_data, e.data);
          check("sb_op", rsp_op, e.op);
          check("sb_tag", rsp_tag, e.tag);
          check("sb_dz", rsp_dz, e.dz);
        end
        last_pop_tag = rsp_tag;
        n_pop++;
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() >= 4) check("accept_while_full", 1, 0);
        exp_q.push_back(ref_rsp(cmd_op, cmd_a, cmd_b, n_acc));
        n_acc++;
      end
    end
  end

  task automatic wait_accept();
    bit done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) check("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic send(input int op, input int a, input int b);
    cmd_op = 3'(op);
    cmd_a = 4'(a);
    cmd_b = 4'(b);
    cmd_valid = 1'b1;
    wait_accept();
  endtask

  task automatic run_cmd(input int op, input int a, input int b,
                         input logic [7:0] ed, input logic edz, input logic [3:0] etag);
    bit seen = 0;
    send(op, a, b);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check("rsp_valid_wait", seen, 1);
    check("rsp_data", rsp_data, ed);
    check("rsp_dz", rsp_dz, edz);
    check("rsp_tag", rsp_tag, etag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_alu_operands", alu_operands, 8'h00);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_data, rsp_op, rsp_tag, rsp_dz}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic add with exact latency
    cmd_op = 3'd0; cmd_a = 4'd3; cmd_b = 4'd5; cmd_valid = 1'b1;
    wait_accept();
    check("add_operands", alu_operands, 8'h35);
    check("add_ready_e0", cmd_ready, 0);
    check("add_busy_e0", busy, 1);
    @(posedge clk); #1;
    check("add_ready_e1", cmd_ready, 0);
    check("add_valid_e1", rsp_valid, 0);
    @(posedge clk); #1;
    check("add_valid_e2", rsp_valid, 1);
    check("add_data", rsp_data, 8'h08);
    check("add_op", rsp_op, 0);
    check("add_tag", rsp_tag, 0);
    check("add_dz", rsp_dz, 0);
    check("add_busy_e2", busy, 0);
    check("add_ready_after", cmd_ready, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("add_popped", rsp_valid, 0);

    // Wrap, multiply, divide-by-zero
    do_reset();
    run_cmd(1, 3, 5, 8'hFE, 0, 4'd0);
    run_cmd(3, 15, 15, 8'hE1, 0, 4'd1);
    run_cmd(4, 9, 0, 8'hFF, 1, 4'd2);
    run_cmd(5, 0, 7, 8'hFF, 1, 4'd3);
    run_cmd(4, 9, 2, 8'h04, 0, 4'd4);
    run_cmd(2, 3, 5, 8'h02, 0, 4'd5);

    // Backpressure: four fill the FIFO, fifth waits for a pop
    do_reset();
    for (int i = 0; i < 4; i++) send($urandom_range(7), $urandom_range(15), $urandom_range(15));
    idle_cycles(3);
    check("bp_accepted4", n_acc, 4);
    check("bp_ready_full", cmd_ready, 0);
    check("bp_head_tag", rsp_tag, 0);
    cmd_op = 3'd6; cmd_a = 4'hC; cmd_b = 4'hA; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_ready_held", cmd_ready, 0);
    end
    check("bp_still4", n_acc, 4);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_ready_after_pop", cmd_ready, 1);
    check("bp_new_head_tag", rsp_tag, 1);
    wait_accept();
    check("bp_accepted5", n_acc, 5);
    rsp_ready = 1'b1;
    idle_cycles(8);
    rsp_ready = 1'b0;
    check("bp_drained", n_pop, 5);
    check("bp_last_tag", last_pop_tag, 4);

    // Tag wrap with continuous draining
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) send($urandom_range(7), $urandom_range(15), $urandom_range(15));
    idle_cycles(5);
    check("wrap_pops", n_pop, 17);
    check("wrap_last_tag", last_pop_tag, 0);
    check("wrap_q_empty", exp_q.size(), 0);
    rsp_ready = 1'b0;

    // Reset during WAIT with responses queued
    do_reset();
    send(0, 1, 1);
    send(0, 2, 2);
    idle_cycles(3);
    send(0, 3, 3);
    check("mid_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_operands", alu_operands, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cmd(0, 1, 2, 8'h03, 0, 4'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(1) == 1);
      cmd_op    = 3'($urandom_range(7));
      cmd_a     = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
      cmd_b     = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
      rsp_ready = ($urandom_range(9) < 6);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    idle_cycles(10);
    check("rand_q_empty", exp_q.size(), 0);
    check("rand_pop_eq_acc", n_pop, n_acc);
    check("rand_idle_ready", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
